// File: rtl/data_memory_lanes.sv
// Byte-addressed, lane-aware data memory with per-byte initialisation tracking and pipelined responses.
// Defining DATA_MEMORY_LANES_STATS_EN adds saturating load/store/fault counters.
module data_memory_lanes #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_uninit,
   output logic                  resp_fault
`ifdef DATA_MEMORY_LANES_STATS_EN
   ,
   output logic [31:0]           stat_loads,
   output logic [31:0]           stat_stores,
   output logic [31:0]           stat_faults
`endif
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(LANES);
   localparam int IW    = $clog2(DEPTH);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state;
   logic [IW-1:0]         clear_idx;
   logic [LANES-1:0]      byte_valid [DEPTH];
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  accept;
   logic [IW-1:0]         word_idx;
   logic [LSB-1:0]        lane_off;
   logic [7:0]            size_bytes;
   logic [2:0]            align_mask;
   logic [LANES-1:0]      size_lanes;
   logic [LANES-1:0]      sel_mask;
   logic                  size_fault;
   logic                  align_fault;
   logic                  range_fault;
   logic                  fault;
   logic                  do_store;
   logic                  do_load;

   logic [DATA_WIDTH-1:0] rd_word;
   logic [LANES-1:0]      rd_valid;
   logic [DATA_WIDTH-1:0] rd_masked;
   logic [DATA_WIDTH-1:0] rd_shift;
   logic [DATA_WIDTH-1:0] keep_mask;
   logic                  sign_bit;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_uninit;
   logic [DATA_WIDTH-1:0] wr_shift;

   logic [READ_LATENCY-1:0] pipe_valid;
   logic [READ_LATENCY-1:0] pipe_uninit;
   logic [READ_LATENCY-1:0] pipe_fault;
   logic [DATA_WIDTH-1:0]   pipe_rdata [READ_LATENCY];

   assign accept   = req_valid & req_ready & ~reset;
   assign word_idx = req_addr[LSB +: IW];
   assign lane_off = req_addr[LSB-1:0];

   always_comb begin
      case (req_size)
         2'd0:    begin size_bytes = 8'h01; align_mask = 3'b000; end
         2'd1:    begin size_bytes = 8'h03; align_mask = 3'b001; end
         2'd2:    begin size_bytes = 8'h0F; align_mask = 3'b011; end
         default: begin size_bytes = 8'hFF; align_mask = 3'b111; end
      endcase
   end

   assign size_lanes  = LANES'(size_bytes);
   assign sel_mask    = size_lanes << lane_off;
   assign size_fault  = {1'b0, req_size} > 3'(LSB);
   assign align_fault = |(req_addr[2:0] & align_mask);

   // Anything above the last byte of the last word is out of range.
   generate
      if (ADDR_WIDTH > LSB + IW) begin : g_range
         assign range_fault = |req_addr[ADDR_WIDTH-1:LSB+IW];
      end else begin : g_no_range
         assign range_fault = 1'b0;
      end
   endgenerate

   assign fault    = size_fault | align_fault | range_fault;
   assign do_store = accept & req_write & ~fault;
   assign do_load  = accept & ~req_write & ~fault;

   // Never-written bytes read as zero, then the selection is right-justified and extended.
   always_comb begin
      rd_word   = mem[word_idx];
      rd_valid  = byte_valid[word_idx];
      rd_masked = '0;
      keep_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         rd_masked[i*8 +: 8] = rd_valid[i] ? rd_word[i*8 +: 8] : 8'h00;
         keep_mask[i*8 +: 8] = {8{size_lanes[i]}};
      end
      rd_shift = rd_masked >> {lane_off, 3'b000};
      case (req_size)
         2'd0:    sign_bit = rd_shift[7];
         2'd1:    sign_bit = rd_shift[15];
         2'd2:    sign_bit = rd_shift[31];
         default: sign_bit = rd_shift[DATA_WIDTH-1];
      endcase
      load_data   = (rd_shift & keep_mask) |
                    (~keep_mask & {DATA_WIDTH{sign_bit & ~req_unsigned}});
      load_uninit = |(sel_mask & ~rd_valid);
   end

   assign wr_shift = req_wdata << {lane_off, 3'b000};

   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int i = 0; i < LANES; i++) begin
            if (sel_mask[i]) begin
               mem[word_idx][i*8 +: 8] <= wr_shift[i*8 +: 8];
            end
         end
      end
   end

   // CLEAR sweeps the byte-valid bits one word per cycle before requests are taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CLEAR;
         clear_idx <= '0;
         req_ready <= 1'b0;
      end else if (state == CLEAR) begin
         byte_valid[clear_idx] <= '0;
         clear_idx             <= clear_idx + 1'b1;
         if (clear_idx == IW'(DEPTH - 1)) begin
            state     <= RUN;
            req_ready <= 1'b1;
         end
      end else begin
         req_ready <= 1'b1;
         if (do_store) begin
            for (int i = 0; i < LANES; i++) begin
               if (sel_mask[i]) begin
                  byte_valid[word_idx][i] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid  <= '0;
         pipe_uninit <= '0;
         pipe_fault  <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_rdata[i] <= '0;
         end
      end else begin
         pipe_valid[0]  <= accept;
         pipe_fault[0]  <= accept & fault;
         pipe_uninit[0] <= do_load & load_uninit;
         pipe_rdata[0]  <= do_load ? load_data : '0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i]  <= pipe_valid[i-1];
            pipe_fault[i]  <= pipe_fault[i-1];
            pipe_uninit[i] <= pipe_uninit[i-1];
            pipe_rdata[i]  <= pipe_rdata[i-1];
         end
      end
   end

   assign resp_valid  = pipe_valid[READ_LATENCY-1];
   assign resp_fault  = pipe_fault[READ_LATENCY-1];
   assign resp_uninit = pipe_uninit[READ_LATENCY-1];
   assign resp_rdata  = pipe_rdata[READ_LATENCY-1];

`ifdef DATA_MEMORY_LANES_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_faults <= '0;
      end else if (accept) begin
         if (fault) begin
            if (stat_faults != 32'hFFFF_FFFF) stat_faults <= stat_faults + 32'd1;
         end else if (req_write) begin
            if (stat_stores != 32'hFFFF_FFFF) stat_stores <= stat_stores + 32'd1;
         end else begin
            if (stat_loads != 32'hFFFF_FFFF) stat_loads <= stat_loads + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_memory_lanes.sv
// Bench for data_memory_lanes: two instances (read latency 1 and 3) share stimulus and are
// compared each cycle against a byte-array reference model, plus a directed vector table.
module tb_data_memory_lanes;

   localparam int DEPTH = 32;
   localparam int BYTES = DEPTH * 4;

   typedef struct packed {
      logic [31:0] rdata;
      logic        uninit;
      logic        fault;
   } resp_t;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_uninit;
      logic        exp_fault;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        ready1, valid1, uninit1, fault1;
   logic [31:0] rdata1;
   logic        ready3, valid3, uninit3, fault3;
   logic [31:0] rdata3;

   logic [7:0]  mem_m [BYTES];
   logic        vld_m [BYTES];
   int          clear_left = DEPTH;
   int          edge_count = 0;
   resp_t       pend1 [int];
   resp_t       pend3 [int];
   int          vectors = 0;
   int          miscompares = 0;
   int          valid1_count = 0;
   int          valid3_count = 0;
   int          valid3_first = -1;
   vec_t        vecs [$];

   always #5 clk = ~clk;

   data_memory_lanes #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(valid1),
      .resp_rdata(rdata1), .resp_uninit(uninit1), .resp_fault(fault1)
   );

   data_memory_lanes #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(valid3),
      .resp_rdata(rdata3), .resp_uninit(uninit3), .resp_fault(fault3)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_count);
      end
   endtask

   // Response implied by the current request against the byte-level model.
   function automatic resp_t modelResp();
      resp_t           r;
      int              n;
      longint unsigned val;
      r = '0;
      n = 1 << req_size;
      if (req_size > 2'd2 || (req_addr % n) != 0 || req_addr >= BYTES) begin
         r.fault = 1'b1;
         return r;
      end
      if (req_write) return r;
      val = 0;
      for (int k = 0; k < n; k++) begin
         if (vld_m[req_addr + k]) val = val + (64'(mem_m[req_addr + k]) << (8 * k));
         else r.uninit = 1'b1;
      end
      if (!req_unsigned && val[8*n-1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      r.rdata = val[31:0];
      return r;
   endfunction

   task automatic modelEdge();
      resp_t r;
      int    n;
      edge_count++;
      if (reset) begin
         pend1.delete();
         pend3.delete();
         clear_left = DEPTH;
         for (int i = 0; i < BYTES; i++) vld_m[i] = 1'b0;
      end else begin
         if (req_valid && clear_left == 0) begin
            r = modelResp();
            pend1[edge_count]     = r;
            pend3[edge_count + 2] = r;
            if (req_write && !r.fault) begin
               n = 1 << req_size;
               for (int k = 0; k < n; k++) begin
                  mem_m[req_addr + k] = req_wdata[8*k +: 8];
                  vld_m[req_addr + k] = 1'b1;
               end
            end
         end
         if (clear_left > 0) clear_left--;
      end
   endtask

   task automatic checkOutput();
      resp_t e;
      cmp("ready_l1", 32'(ready1), 32'(clear_left == 0));
      cmp("ready_l3", 32'(ready3), 32'(clear_left == 0));
      if (valid1) valid1_count++;
      if (valid3) begin
         valid3_count++;
         if (valid3_first < 0) valid3_first = edge_count;
      end
      if (pend1.exists(edge_count)) begin
         e = pend1[edge_count];
         pend1.delete(edge_count);
         cmp("valid_l1", 32'(valid1), 32'd1);
         cmp("rdata_l1", rdata1, e.rdata);
         cmp("uninit_l1", 32'(uninit1), 32'(e.uninit));
         cmp("fault_l1", 32'(fault1), 32'(e.fault));
      end else begin
         cmp("idle_l1", 32'(valid1), 32'd0);
      end
      if (pend3.exists(edge_count)) begin
         e = pend3[edge_count];
         pend3.delete(edge_count);
         cmp("valid_l3", 32'(valid3), 32'd1);
         cmp("rdata_l3", rdata3, e.rdata);
         cmp("uninit_l3", 32'(uninit3), 32'(e.uninit));
         cmp("fault_l3", 32'(fault3), 32'(e.fault));
      end else begin
         cmp("idle_l3", 32'(valid3), 32'd0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      tick();
      req_valid    = 1'b0;
   endtask

   task automatic waitReady(input string name);
      int n = 0;
      while (!ready1 && n < 200) begin
         tick();
         n++;
      end
      cmp(name, 32'(ready1), 32'd1);
   endtask

   function automatic vec_t mkVec(input logic wr, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] er, input logic eu, input logic ef);
      vec_t v;
      v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = er; v.exp_uninit = eu; v.exp_fault = ef;
      return v;
   endfunction

   initial begin
      int          n;
      int          first_acc;
      logic [31:0] a;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset sweep length: ready stays low for DEPTH cycles after a one-cycle reset.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n = 1;
      while (!ready1 && n < 100) begin
         tick();
         if (!ready1) n++;
      end
      cmp("sweep_cycles", 32'(n), 32'(DEPTH));

      vecs.push_back(mkVec(1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0000_0000, 0, 0));
      vecs.push_back(mkVec(0, 2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 32'h13, 32'h0,        32'hFFFF_FFDE, 0, 0));
      vecs.push_back(mkVec(0, 0, 1, 32'h13, 32'h0,        32'h0000_00DE, 0, 0));
      vecs.push_back(mkVec(0, 1, 0, 32'h12, 32'h0,        32'hFFFF_DEAD, 0, 0));
      vecs.push_back(mkVec(1, 0, 0, 32'h21, 32'h0000_007F, 32'h0000_0000, 0, 0));
      vecs.push_back(mkVec(0, 2, 0, 32'h20, 32'h0,        32'h0000_7F00, 1, 0));
      vecs.push_back(mkVec(1, 1, 0, 32'h05, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1));
      vecs.push_back(mkVec(0, 2, 0, 32'h04, 32'h0,        32'h0000_0000, 1, 0));
      vecs.push_back(mkVec(0, 2, 0, 32'h80, 32'h0,        32'h0000_0000, 0, 1));
      vecs.push_back(mkVec(0, 3, 0, 32'h00, 32'h0,        32'h0000_0000, 0, 1));
      vecs.push_back(mkVec(0, 1, 1, 32'h10, 32'h0,        32'h0000_BEEF, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 32'h11, 32'h0,        32'hFFFF_FFBE, 0, 0));
      vecs.push_back(mkVec(1, 1, 0, 32'h22, 32'h1234_8001, 32'h0000_0000, 0, 0));
      vecs.push_back(mkVec(0, 2, 0, 32'h20, 32'h0,        32'h8001_7F00, 1, 0));
      vecs.push_back(mkVec(0, 1, 0, 32'h22, 32'h0,        32'hFFFF_8001, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
         cmp($sformatf("tbl%0d_valid", i), 32'(valid1), 32'd1);
         cmp($sformatf("tbl%0d_rdata", i), rdata1, vecs[i].exp_rdata);
         cmp($sformatf("tbl%0d_uninit", i), 32'(uninit1), 32'(vecs[i].exp_uninit));
         cmp($sformatf("tbl%0d_fault", i), 32'(fault1), 32'(vecs[i].exp_fault));
      end
      repeat (4) tick();

      // Four back-to-back loads through the latency-3 instance.
      valid3_count = 0;
      valid3_first = -1;
      first_acc = edge_count + 1;
      applyStimulus(0, 2, 0, 32'h10, 32'h0);
      applyStimulus(0, 1, 0, 32'h12, 32'h0);
      applyStimulus(0, 0, 1, 32'h13, 32'h0);
      applyStimulus(0, 2, 0, 32'h20, 32'h0);
      repeat (6) tick();
      cmp("pipe_resp_count", 32'(valid3_count), 32'd4);
      cmp("pipe_first_edge", 32'(valid3_first), 32'(first_acc + 2));

      // Reset right after the second acceptance drops everything still in flight.
      applyStimulus(0, 2, 0, 32'h10, 32'h0);
      applyStimulus(0, 1, 0, 32'h12, 32'h0);
      valid1_count = 0;
      valid3_count = 0;
      reset = 1'b1;
      req_valid = 1'b1;
      tick();
      reset = 1'b0;
      req_valid = 1'b0;
      repeat (8) tick();
      cmp("post_reset_resp_l3", 32'(valid3_count), 32'd0);
      cmp("post_reset_resp_l1", 32'(valid1_count), 32'd0);
      waitReady("ready_after_midreset");

      // Randomised traffic with occasional resets.
      for (int c = 0; c < 800; c++) begin
         reset        = ($urandom_range(0, 249) == 0);
         req_valid    = ($urandom_range(0, 3) != 0);
         req_write    = 1'($urandom_range(0, 1));
         req_unsigned = 1'($urandom_range(0, 1));
         req_size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63));
         if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << req_size) - 32'd1);
         req_addr  = a;
         req_wdata = $urandom();
         tick();
      end
      reset = 1'b0;
      req_valid = 1'b0;
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_memory_lanes.md
Name: data_memory_lanes

Overview:
- Parametrised successor to the processor's single-word data memory.
- Byte-addressed and lane-aware: byte, half and word (and dword at 64-bit) loads and stores, with sign or zero extension.
- Pipelined request/response with configurable read latency.
- Tracks initialisation per byte; the tracking is cleared by a reset sweep FSM.
- Sits between the MEM stage and backing storage; request interface matches the MEM-stage control signals.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32 or 64; LANES = DATA_WIDTH/8.
- DEPTH, 32, number of words; power of two, at least 4.
- ADDR_WIDTH, 32, byte-address width.
- READ_LATENCY, 1, cycles from acceptance to response; legal 1..4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access is 2^req_size bytes.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  response present, one cycle per accepted request.
- resp_rdata  out  DATA_WIDTH  load result; 0 for stores and faults.
- resp_uninit  out  1  load touched at least one never-written byte.
- resp_fault  out  1  request was misaligned, out of range or illegal size.

Behaviour:
- Interface: clock is clk; reset is synchronous, active-high, named reset.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_uninit=0, resp_fault=0.
- In-flight responses are discarded when reset is asserted. Memory contents are not cleared, but every byte becomes uninitialised.
- FSM, two states:
  - CLEAR: entered on reset. A counter walks words 0..DEPTH-1, clearing that word's LANES byte-valid bits, one word per cycle. req_ready=0. Moves to RUN after word DEPTH-1 is cleared. Reset asserted again mid-sweep restarts the counter at 0.
  - RUN: req_ready=1 every cycle. A request is accepted on a cycle with req_valid && req_ready.
- Fault check, done in the acceptance cycle. Fault if any of:
  - req_size > log2(LANES);
  - req_addr not aligned to 2^req_size;
  - req_addr >= DEPTH*LANES.
  A faulting store writes nothing. A faulting load returns resp_rdata=0, resp_uninit=0.
- Store:
  - Word index = req_addr / LANES; lane offset = req_addr mod LANES.
  - The low 2^req_size bytes of req_wdata are written to lanes offset.., and those bytes' valid bits are set at the acceptance edge.
  - Other lanes are unchanged.
- Load:
  - The selected bytes are read at the acceptance edge and right-justified.
  - Upper bits are filled with copies of the top selected bit when req_unsigned=0, else with 0.
  - Any selected byte with valid=0 reads as 0x00 and sets resp_uninit.
- Ordering:
  - A store accepted at edge N is visible to a load accepted at edge N+1 or later.
  - At most one request per cycle, so there is no same-cycle read/write conflict.
- Latency:
  - The response for a request accepted at edge N appears with resp_valid=1 in the cycle following edge N+READ_LATENCY-1.
  - Back-to-back requests give back-to-back responses, in order.
  - Stores also return a response, with rdata=0.
  - No response backpressure.

Optional Feature:
- Macro: DATA_MEMORY_LANES_STATS_EN.
- When defined, three extra outputs are added, each 32 bits: stat_loads, stat_stores, stat_faults.
  - Each counts accepted requests of its kind; faults count in stat_faults only.
  - All three saturate at 0xFFFFFFFF and clear to 0 on reset.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset sweep, DEPTH=32: assert reset 1 cycle -> req_ready=0 for exactly 32 cycles, then 1.
- Word store then load: store 0xDEADBEEF at 0x10, load word at 0x10 with READ_LATENCY=1 -> next-cycle resp_rdata=0xDEADBEEF, uninit=0, fault=0.
- Byte and half extension on the same word:
  - Byte load at 0x13, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
  - Half load at 0x12, signed -> 0xFFFFDEAD.
- Partial initialisation after reset: store byte 0x7F at 0x21, load word at 0x20 -> rdata=0x00007F00, resp_uninit=1.
- Faults:
  - Half store at 0x05 -> resp_fault=1, memory unchanged.
  - Word load at 0x80 with DEPTH=32 -> fault=1, rdata=0.
  - size=3 with DATA_WIDTH=32 -> fault=1.
- READ_LATENCY=3 pipelining with mid-stream reset:
  - 4 back-to-back loads -> 4 consecutive responses starting 3 cycles after the first acceptance, in order.
  - Reset asserted after the second acceptance -> no further resp_valid; CLEAR restarts.
